// File: rtl/tone_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen_pkg
//  Description : Shared constants and the amplitude-shift helper for the
//                multi-channel square-wave tone generator.
//                  AUDIO_W      - sample width of every channel
//                  AMP_HI/LO    - full-scale high/low square levels
//                  REST_DIV_MAX - largest divider value treated as a rest
//                  amp_shift()  - scales a full-scale level by a right shift
//  Revision    : 1.0 - initial release
// ============================================================================
package tone_gen_pkg;

    localparam int                 AUDIO_W      = 16;
    localparam logic [AUDIO_W-1:0] AMP_HI       = 16'hE000;
    localparam logic [AUDIO_W-1:0] AMP_LO       = 16'h2000;
    localparam int                 REST_DIV_MAX = 1;

    // A right shift of the full-scale level gives the volume-scaled level,
    // so no divider or multiplier is needed.
    function automatic logic [AUDIO_W-1:0] amp_shift(
        input logic [AUDIO_W-1:0] base,
        input int                 sh
    );
        return base >> sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tone_channel
//  Description : One square-wave tone channel. Holds the half-period
//                counter, the square polarity, the previously seen divider
//                (for note-change detection) and the registered sample.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_en            - channel enable
//                i_div           - half-period divider (0/1 = rest)
//                i_silence       - forces the sample to 0 (mute / volume 0)
//                i_amp_hi/lo     - volume-scaled high/low levels
//                o_phase         - current square polarity
//                o_audio         - registered sample
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_channel
    import tone_gen_pkg::*;
#(
    parameter int DIV_W = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [DIV_W-1:0]   i_div,
    input  logic               i_silence,
    input  logic [AUDIO_W-1:0] i_amp_hi,
    input  logic [AUDIO_W-1:0] i_amp_lo,
    output logic               o_phase,
    output logic [AUDIO_W-1:0] o_audio
);

    logic [DIV_W-1:0]   r_cnt;
    logic               r_phase;
    logic [DIV_W-1:0]   r_prev_div;
    logic [AUDIO_W-1:0] r_sample;

    logic w_active;
    logic w_change;

    assign w_active = i_en && (i_div > DIV_W'(REST_DIV_MAX));
    assign w_change = (i_div != r_prev_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_phase    <= 1'b0;
            r_prev_div <= '0;
            r_sample   <= '0;
        end else begin
            r_prev_div <= i_div;
            // Sample is taken from the polarity currently held, so it trails
            // o_phase by one clock.
            r_sample   <= (i_silence || !w_active) ? '0
                        : (r_phase ? i_amp_lo : i_amp_hi);
            // A note change outranks the toggle so every new note starts on
            // a full-length high half.
            if (!w_active || w_change) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_cnt == i_div) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + DIV_W'(1);
            end
        end
    end

    assign o_phase = r_phase;
    assign o_audio = r_sample;

endmodule
`default_nettype wire

// File: rtl/tone_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tone_gen_multi
//  Description : Parametrised multi-channel square-wave tone generator.
//                Holds the button sample tick, the volume up/down edge
//                detectors and the saturating volume register, and feeds
//                the volume-scaled levels to every channel.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                volume_up, volume_down   - synchronised button levels
//                mute                     - forces all audio to 0
//                ch_en[CHANNELS]          - per-channel enable
//                note_div[CHANNELS*DIV_W] - per-channel dividers
//                audio[CHANNELS*16]       - per-channel samples
//                phase[CHANNELS]          - per-channel square polarity
//                volume[VOL_W]            - current volume level
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_gen_multi
    import tone_gen_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int DIV_W     = 22,
    parameter int VOL_W     = 2,
    parameter int VOL_INIT  = 2,
    parameter int TICK_LOG2 = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        volume_up,
    input  logic                        volume_down,
    input  logic                        mute,
    input  logic [CHANNELS-1:0]         ch_en,
    input  logic [CHANNELS*DIV_W-1:0]   note_div,
    output logic [CHANNELS*AUDIO_W-1:0] audio,
    output logic [CHANNELS-1:0]         phase,
    output logic [VOL_W-1:0]            volume
);

    localparam logic [VOL_W-1:0] c_vol_max    = '1;
    localparam int               c_shift_base = (1 << VOL_W);   // VOL_MAX + 1

    logic [TICK_LOG2-1:0] r_tick_cnt;
    logic                 r_up_q;
    logic                 r_dn_q;
    logic [VOL_W-1:0]     r_volume;

    logic                 w_tick;
    logic                 w_up_edge;
    logic                 w_dn_edge;
    logic                 w_silence;
    logic [AUDIO_W-1:0]   w_amp_hi;
    logic [AUDIO_W-1:0]   w_amp_lo;

    // Tick fires on the cycle the free-running counter is about to wrap.
    assign w_tick = &r_tick_cnt;

    // Edges are judged against the level captured on the previous tick.
    assign w_up_edge = w_tick && volume_up   && !r_up_q;
    assign w_dn_edge = w_tick && volume_down && !r_dn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_up_q     <= 1'b0;
            r_dn_q     <= 1'b0;
            r_volume   <= VOL_W'(VOL_INIT);
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_LOG2'(1);
            if (w_tick) begin
                r_up_q <= volume_up;
                r_dn_q <= volume_down;
            end
            // Simultaneous up and down edges cancel out.
            if (w_up_edge && !w_dn_edge && (r_volume != c_vol_max)) begin
                r_volume <= r_volume + VOL_W'(1);
            end else if (w_dn_edge && !w_up_edge && (r_volume != '0)) begin
                r_volume <= r_volume - VOL_W'(1);
            end
        end
    end

    assign w_amp_hi  = amp_shift(AMP_HI, c_shift_base - int'(r_volume));
    assign w_amp_lo  = amp_shift(AMP_LO, c_shift_base - int'(r_volume));
    assign w_silence = mute || (r_volume == '0);
    assign volume    = r_volume;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        tone_channel #(
            .DIV_W (DIV_W)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en      (ch_en[k]),
            .i_div     (note_div[k*DIV_W +: DIV_W]),
            .i_silence (w_silence),
            .i_amp_hi  (w_amp_hi),
            .i_amp_lo  (w_amp_lo),
            .o_phase   (phase[k]),
            .o_audio   (audio[k*AUDIO_W +: AUDIO_W])
        );
    end

endmodule
`default_nettype wire

// File: doc/tone_gen_multi.md
# tone_gen_multi

Parametrised multi-channel square-wave tone generator, the successor to the two-channel note generator. It produces one 16-bit audio sample stream per channel from a per-channel half-period divider. Each channel has its own enable, a global mute and a saturating volume control, and the phase restarts cleanly on every note change. It sits between the melody/player control logic and the audio serialiser (I2S/DAC front end), all in the system clock domain.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent tone channels (≥1).
- `DIV_W`, 22: width of each half-period divider.
- `VOL_W`, 2: volume width; levels 0..VOL_MAX, VOL_MAX = 2^VOL_W−1.
- `VOL_INIT`, 2: volume after reset.
- `TICK_LOG2`, 15: button sample period is 2^TICK_LOG2 clk cycles.

Ports:
- `clk` in 1: system clock, all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `volume_up` in 1: volume-up button level, already synchronised.
- `volume_down` in 1: volume-down button level, already synchronised.
- `mute` in 1: forces all audio to 0 while high.
- `ch_en` in CHANNELS: per-channel enable.
- `note_div` in CHANNELS*DIV_W: channel k divider at [k*DIV_W +: DIV_W]. Values 0 and 1 mean rest.
- `audio` out CHANNELS*16: channel k sample at [k*16 +: 16].
- `phase` out CHANNELS: current square polarity per channel, for debug and scope.
- `volume` out VOL_W: current volume level.

## Operation
- Per channel, `cnt` (DIV_W bits) counts 0..div. When `cnt == div`, `cnt` goes to 0 and `phase` toggles. The half period is div+1 cycles and the full period is 2*(div+1) cycles.
- A channel is active when ch_en=1 and note_div ≥ 2. An inactive channel holds cnt=0 and phase=0.
- Note change: each channel registers its previous div. If the current div differs from it, then in that cycle cnt←0 and phase←0, and counting resumes from 0 on the next cycle. The first sample of the new note is always the high half.
- Amplitude: hi = 16'hE000 >> (VOL_MAX+1−volume), lo = 16'h2000 >> (VOL_MAX+1−volume). Constant-shift mux; no divider.
- Sample: audio = 0 if mute, volume==0 or the channel is inactive. Otherwise audio = hi when phase=0 and lo when phase=1.
- Volume tick: a free-running TICK_LOG2-bit counter produces a one-cycle `tick` at wrap. Buttons are sampled only on tick.
- Edge rule: a step happens only on a sampled 0→1 transition, relative to the previous tick's sample. One step per press; no auto-repeat.
- Up edge with volume<VOL_MAX: +1. Down edge with volume>0: −1. Saturates at both ends and never wraps.
- Up and down edges on the same tick: no change.
- `mute` does not change `volume`.

## Timing
- Reset values: all cnt=0, phase=0, audio=0, volume=VOL_INIT, tick counter=0, button samples=0, stored div=0.
- audio and phase are registered. audio reflects phase/volume/mute/ch_en/div one clk after each changes (1-cycle latency).
- volume updates on the clk edge at which tick=1. A press held across two ticks produces exactly one step.
- Reset asserted mid-note clears everything immediately (async). After release, a nonzero div is seen as a change from stored 0, so the note starts from phase 0.
- A div change on the same cycle as the toggle condition takes restart priority.

## Structure
- Package `tone_gen_pkg` holds: AUDIO_W=16, AMP_HI=16'hE000, AMP_LO=16'h2000, REST_DIV_MAX=1, and the amplitude-shift helper function.
- Sub-module `tone_channel` holds one channel's cnt, phase, stored div, active logic and sample register. It is instantiated CHANNELS times with a generate loop.
- Top level holds the tick counter, the button edge detectors and the volume register, and broadcasts hi/lo amplitudes to all channels.

## Test plan
- Reset then idle: during and after rst_n low, audio=0, phase=0 and volume=2. With ch_en=0, audio stays 0 for 1000 cycles.
- Period: ch0 div=3, ch_en=1, volume=3 (hi=16'h7000, lo=16'h1000). audio alternates 4 cycles 16'h7000 and 4 cycles 16'h1000. ch1 at div=5 is independent, with 6/6 cycles.
- Volume: from volume 2, two up presses give 3 and stay 3, with the second press saturating. Four down presses give 0 and then audio=0. A press held for 5 ticks gives exactly one step. Simultaneous up and down edges give no change.
- Note change: switch div from 5 to 3 mid-high-half. The next cycle shows cnt=0 and phase=0, then 4 cycles high. Switching to div=1 gives audio=0 after 1 cycle.
- Mute: asserting mute gives audio=0 one cycle later while phase keeps toggling. Deasserting mute resumes with the correct phase, and volume is unchanged.
- Async reset mid-note: pulse rst_n low between clk edges. Outputs clear without waiting for a clk edge, and after release the note restarts from phase 0.
